vitis_net_p4: RTL and testbench
===============================

Name: vitis_net_p4

Overview:
- AXI4-Stream packet classifier stage that stands in for the P4 packet-split pipeline.
- Accepts packets on a 512-bit slave stream together with a per-packet user metadata word.
- Parses the Ethernet/IPv4 header from the first beat, writes a 2-bit traffic class into the metadata and forwards packet and metadata unchanged on a master stream.
- Sits between the MAC TX interface and the egress-port splitter.

Parameters:
- TDATA_NUM_BYTES, 64, stream width in bytes (tdata = 8*TDATA_NUM_BYTES bits); must be >= 24.
- USER_META_DATA_WIDTH, 9, metadata width (egress-port field); must be >= 2.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  reset; asynchronous, active-low.
- user_metadata_in  in  USER_META_DATA_WIDTH  per-packet metadata, sampled with first beat.
- user_metadata_in_valid  in  1  qualifies user_metadata_in.
- user_metadata_out  out  USER_META_DATA_WIDTH  classified metadata.
- user_metadata_out_valid  out  1  metadata valid strobe.
- s_axis_tdata  in  8*TDATA_NUM_BYTES  input data; byte 0 in bits [7:0] is first on the wire.
- s_axis_tkeep  in  TDATA_NUM_BYTES  byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  end of packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  8*TDATA_NUM_BYTES  output data.
- m_axis_tkeep  out  TDATA_NUM_BYTES  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  end of packet.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0, including s_axis_tready.
  - The in-packet flag clears, so the next accepted beat is a first beat.
  - Reset mid-packet discards the partial packet and any held output beat.
- Transfer rule: a beat transfers when valid and ready are both high in the same cycle.
- Output register stage:
  - One beat deep, holding data, keep, last and the metadata.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational); it is 0 while in reset.
  - An accepted beat appears on m_axis the next cycle (latency 1).
  - Simultaneous output handshake and input accept reloads the register with no bubble, sustaining 1 beat/cycle.
  - With m_axis_tready low, outputs stay stable and tvalid stays high; no data is lost.
- Data passthrough:
  - tdata, tkeep and tlast are forwarded unmodified.
  - tkeep is not used for parsing; a first beat with tkeep = 0 is still parsed.
- First-beat detection: a beat is a first beat when the in-packet flag is clear. The flag sets on an accepted beat with tlast=0 and clears on an accepted beat with tlast=1.
- Classification, computed on the first beat only (B[n] = byte n of tdata):
  - ethertype = {B[12], B[13]}.
  - class = 0 when ethertype != 16'h0800.
  - Otherwise, with protocol = B[23]: class = 1 when protocol == 6 (TCP), 2 when protocol == 17 (UDP), 3 for any other protocol.
- Metadata composition:
  - Base = user_metadata_in if user_metadata_in_valid is high on the first beat, else 0.
  - Packet metadata = {base[W-1:2], class[1:0]}.
  - It is latched in a packet register and attached to every beat of that packet in the output stage.
  - user_metadata_in is ignored on non-first beats.
- Metadata output:
  - user_metadata_out = the output stage's metadata; it is held while that stage is valid.
  - user_metadata_out_valid = m_axis_tvalid && m_axis_tlast, so metadata transfers with the packet's last beat.
- Single-beat packet (tlast on the first beat) is fully supported; metadata is valid on the cycle after accept.

Decomposition:
- Shared package vitis_net_p4_pkg holds:
  - constants ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_TCP = 8'd6, IP_PROTO_UDP = 8'd17;
  - byte offsets ETH_TYPE_OFF = 12, IP_PROTO_OFF = 23;
  - typedef class_t (2-bit enum NON_IP, TCP, UDP, IP_OTHER).
- One sub-module is natural: p4_hdr_classify, purely combinational, taking the first-beat tdata and producing class_t.

Test Plan:
- Reset: hold aresetn=0 for 5 cycles -> every output 0; after release, s_axis_tready=1 with m_axis idle.
- Non-IP beat:
  - Stimulus: single beat, tdata = 512'h79f29860f32125f2052c4ae1080046270045fd3b6acf41010ffdbe741803c0a80301e37452ad (bytes 12/13 = fd/0f), tkeep=0, tlast=1, metadata_in=0 with valid=1, m_axis_tready=0.
  - Response: next cycle m_axis_tvalid=1 with identical tdata, tkeep=0 and tlast=1; metadata_out=0 with valid=1; s_axis_tready=0 until m_axis_tready rises.
- TCP packet: B[12]=08, B[13]=00, B[23]=06, metadata_in=9'h1F0, 3 beats -> all 3 beats forwarded in order; metadata_out=9'h1F1, valid only on the third beat.
- UDP/other: B[23]=0x11 with metadata_in_valid=0 -> metadata_out=9'h002; B[23]=0x01 -> class 3 (9'h003).
- Backpressure: toggle m_axis_tready 1/0 each cycle over a 4-beat packet -> no beat dropped or duplicated and outputs stable while stalled; with tready held at 1, throughput is 1 beat/cycle.
- Reset mid-packet: assert aresetn=0 after beat 2 of 4 -> outputs clear; the next accepted beat is treated as a first beat and classified.

Source files
------------

// File: rtl/vitis_net_p4_pkg.sv
// Shared constants and types for the vitis_net_p4 packet classifier stage.
// Header byte offsets are counted from byte 0 (tdata[7:0]), the first byte on the wire.
package vitis_net_p4_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    localparam int ETH_TYPE_OFF = 12;
    localparam int IP_PROTO_OFF = 23;
    // Bytes of the first beat that the classifier actually looks at.
    localparam int HDR_BYTES    = 24;

    typedef enum logic [1:0] {
        NON_IP   = 2'd0,
        TCP      = 2'd1,
        UDP      = 2'd2,
        IP_OTHER = 2'd3
    } class_t;

endpackage

// File: rtl/p4_hdr_classify.sv
// Combinational Ethernet/IPv4 header classifier: maps the leading header bytes of a
// packet's first beat to a 2-bit traffic class.
module p4_hdr_classify
    import vitis_net_p4_pkg::*;
(
    input  logic [8*HDR_BYTES-1:0] hdr,
    output class_t                 pkt_class
);

    logic [15:0] ethertype;
    logic [7:0]  protocol;

    always_comb begin
        ethertype = {hdr[ETH_TYPE_OFF*8 +: 8], hdr[(ETH_TYPE_OFF+1)*8 +: 8]};
        protocol  = hdr[IP_PROTO_OFF*8 +: 8];
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        pkt_class = NON_IP;
        if (ethertype == ETHERTYPE_IPV4) begin
            if (protocol == IP_PROTO_TCP) begin
                pkt_class = TCP;
            end else if (protocol == IP_PROTO_UDP) begin
                pkt_class = UDP;
            end else begin
                pkt_class = IP_OTHER;
            end
        end
    end

endmodule

// File: rtl/vitis_net_p4.sv
// AXI4-Stream classifier stage: forwards packets through a one-beat register slice and
// tags each packet's metadata with the traffic class parsed from its first beat.
module vitis_net_p4
    import vitis_net_p4_pkg::*;
#(
    parameter int TDATA_NUM_BYTES      = 64,
    parameter int USER_META_DATA_WIDTH = 9
) (
    input  logic                              s_axis_aclk,
    input  logic                              s_axis_aresetn,
    input  logic [USER_META_DATA_WIDTH-1:0]   user_metadata_in,
    input  logic                              user_metadata_in_valid,
    output logic [USER_META_DATA_WIDTH-1:0]   user_metadata_out,
    output logic                              user_metadata_out_valid,
    input  logic [8*TDATA_NUM_BYTES-1:0]      s_axis_tdata,
    input  logic [TDATA_NUM_BYTES-1:0]        s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [8*TDATA_NUM_BYTES-1:0]      m_axis_tdata,
    output logic [TDATA_NUM_BYTES-1:0]        m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);

    localparam int DW = 8 * TDATA_NUM_BYTES;
    localparam int MW = USER_META_DATA_WIDTH;

    class_t                  pkt_class;
    logic                    accept;
    logic                    in_pkt;
    logic [MW-1:0]           pkt_meta;
    logic [MW-1:0]           first_meta;
    logic [MW-1:0]           beat_meta;

    logic                    out_valid;
    logic                    out_last;
    logic [DW-1:0]           out_data;
    logic [TDATA_NUM_BYTES-1:0] out_keep;
    logic [MW-1:0]           out_meta;

    p4_hdr_classify u_classify (
        .hdr       (s_axis_tdata[8*HDR_BYTES-1:0]),
        .pkt_class (pkt_class)
    );

    // Ready is forced low during reset so nothing is accepted before the stage is clean.
    assign s_axis_tready = s_axis_aresetn && (!out_valid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        first_meta      = user_metadata_in_valid ? user_metadata_in : '0;
        first_meta[1:0] = pkt_class;
        beat_meta       = in_pkt ? pkt_meta : first_meta;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            in_pkt   <= 1'b0;
            pkt_meta <= '0;
        end else if (accept) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            in_pkt <= !s_axis_tlast;
            if (!in_pkt) begin
                pkt_meta <= first_meta;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            // NOTE: the wide data/keep/meta registers are reset too, because every output must read 0 in reset.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_meta  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= s_axis_tlast;
            out_data  <= s_axis_tdata;
            out_keep  <= s_axis_tkeep;
            out_meta  <= beat_meta;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis_tvalid           = out_valid;
    assign m_axis_tlast            = out_last;
    assign m_axis_tdata            = out_data;
    assign m_axis_tkeep            = out_keep;
    assign user_metadata_out       = out_meta;
    assign user_metadata_out_valid = out_valid && out_last;

endmodule

// File: tb/tb_vitis_net_p4.sv
// Self-checking bench for vitis_net_p4: a queue model of accepted beats is compared
// against the master stream every cycle, plus directed literal expectations.
module tb_vitis_net_p4;

    localparam int NB = 64;
    localparam int W  = 9;
    localparam int DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  user_metadata_in = '0;
    logic          user_metadata_in_valid = 1'b0;
    logic [W-1:0]  user_metadata_out;
    logic          user_metadata_out_valid;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [NB-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [NB-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;

    logic          tready_level = 1'b1;
    logic          bp_toggle = 1'b0;

    always #5 clk = ~clk;

    vitis_net_p4 #(.TDATA_NUM_BYTES(NB), .USER_META_DATA_WIDTH(W)) dut (
        .s_axis_aclk             (clk),
        .s_axis_aresetn          (rst_n),
        .user_metadata_in        (user_metadata_in),
        .user_metadata_in_valid  (user_metadata_in_valid),
        .user_metadata_out       (user_metadata_out),
        .user_metadata_out_valid (user_metadata_out_valid),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tkeep            (s_axis_tkeep),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tlast            (s_axis_tlast),
        .s_axis_tready           (s_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tkeep            (m_axis_tkeep),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tlast            (m_axis_tlast),
        .m_axis_tready           (m_axis_tready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
        logic [W-1:0]  meta;
    } beat_t;

    beat_t        exp_q[$];
    logic         model_in_pkt = 1'b0;
    logic [W-1:0] model_meta = '0;
    int           n_out = 0;
    int           n_meta = 0;
    logic [W-1:0] last_meta = '0;

    function automatic logic [1:0] ref_class(input logic [DW-1:0] d);
        logic [7:0] b [NB];
        for (int i = 0; i < NB; i++) b[i] = d[8*i +: 8];
        if ({b[12], b[13]} != 16'h0800) return 2'd0;
        if (b[23] == 8'd6)  return 2'd1;
        if (b[23] == 8'd17) return 2'd2;
        return 2'd3;
    endfunction

    // Model update on each clock edge: retire the beat the sink took, record the beat the source gave.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                model_in_pkt = 1'b0;
            end else begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (user_metadata_out_valid) begin
                        last_meta = user_metadata_out;
                        n_meta++;
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    n_out++;
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    beat_t bt;
                    if (!model_in_pkt) begin
                        logic [W-1:0] base;
                        base = user_metadata_in_valid ? user_metadata_in : '0;
                        model_meta = {base[W-1:2], ref_class(s_axis_tdata)};
                    end
                    bt.data = s_axis_tdata;
                    bt.keep = s_axis_tkeep;
                    bt.last = s_axis_tlast;
                    bt.meta = model_meta;
                    exp_q.push_back(bt);
                    model_in_pkt = !s_axis_tlast;
                end
            end
        end
    end

    // Compare process, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_m_tvalid", m_axis_tvalid, 0);
                check("rst_m_tlast", m_axis_tlast, 0);
                check("rst_m_tdata", m_axis_tdata, 0);
                check("rst_m_tkeep", m_axis_tkeep, 0);
                check("rst_meta", user_metadata_out, 0);
                check("rst_meta_valid", user_metadata_out_valid, 0);
                check("rst_s_tready", s_axis_tready, 0);
            end else begin
                check("s_tready", s_axis_tready, (exp_q.size() == 0) || m_axis_tready);
                if (exp_q.size() == 0) begin
                    check("idle_m_tvalid", m_axis_tvalid, 0);
                    check("idle_meta_valid", user_metadata_out_valid, 0);
                end else begin
                    check("m_tvalid", m_axis_tvalid, 1);
                    check("m_tdata", m_axis_tdata, exp_q[0].data);
                    check("m_tkeep", m_axis_tkeep, exp_q[0].keep);
                    check("m_tlast", m_axis_tlast, exp_q[0].last);
                    check("meta_out", user_metadata_out, exp_q[0].meta);
                    check("meta_valid", user_metadata_out_valid, exp_q[0].last);
                end
            end
        end
    end

    // Downstream ready: either a fixed level or toggling every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_toggle) m_axis_tready = !m_axis_tready;
            else           m_axis_tready = tready_level;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] mk_hdr(input logic [15:0] et, input logic [7:0] proto,
                                             input logic [31:0] seed);
        logic [DW-1:0] d;
        d = {16{seed}};
        d[12*8 +: 8] = et[15:8];
        d[13*8 +: 8] = et[7:0];
        d[23*8 +: 8] = proto;
        return d;
    endfunction

    task automatic drive_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l,
                              input logic [W-1:0] m, input logic mv, output time t_acc);
        int waited;
        s_axis_tdata           = d;
        s_axis_tkeep           = k;
        s_axis_tlast           = l;
        user_metadata_in       = m;
        user_metadata_in_valid = mv;
        s_axis_tvalid          = 1'b1;
        waited = 0;
        forever begin
            @(posedge clk);
            if (s_axis_tready) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        t_acc = $time;
        #1;
    endtask

    task automatic send_pkt(input logic [DW-1:0] first, input int nbeats, input logic [W-1:0] m,
                            input logic mv, input logic [31:0] seed, output time t_first, output time t_last);
        time t;
        t_first = 0;
        t_last  = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == 0) drive_beat(first, '1, nbeats == 1, m, mv, t);
            else drive_beat({16{seed ^ (32'h01010101 * b)}}, (b == nbeats - 1) ? 64'h0000_00FF_FFFF_FFFF : '1,
                            b == nbeats - 1, ~m, 1'b1, t);
            if (b == 0) t_first = t;
            t_last = t;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 || m_axis_tvalid) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                check("drain_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
    endtask

    logic [DW-1:0] nonip_data;
    time           tf, tl;
    int            out0, meta0;

    initial begin
        nonip_data = 512'h79f29860f32125f2052c4ae1080046270045fd3b6acf41010ffdbe741803c0a80301e37452ad;

        // Reset held for five cycles.
        #2 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_tready", s_axis_tready, 1);
        check("post_rst_m_tvalid", m_axis_tvalid, 0);

        // Classifier literals pinning the model.
        check("ref_nonip", ref_class(nonip_data), 2'd0);
        check("ref_tcp", ref_class(mk_hdr(16'h0800, 8'd6, 32'h0)), 2'd1);
        check("ref_udp", ref_class(mk_hdr(16'h0800, 8'd17, 32'h0)), 2'd2);
        check("ref_other", ref_class(mk_hdr(16'h0800, 8'd1, 32'h0)), 2'd3);

        // Non-IP single beat, tkeep=0, sink stalled.
        tready_level = 1'b0;
        @(posedge clk);
        #2;
        drive_beat(nonip_data, '0, 1'b1, '0, 1'b1, tf);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nonip_tvalid", m_axis_tvalid, 1);
            check("nonip_tdata", m_axis_tdata, nonip_data);
            check("nonip_tkeep", m_axis_tkeep, 0);
            check("nonip_tlast", m_axis_tlast, 1);
            check("nonip_meta", user_metadata_out, 9'h000);
            check("nonip_meta_valid", user_metadata_out_valid, 1);
            check("nonip_s_tready", s_axis_tready, 0);
        end
        tready_level = 1'b1;
        wait_drain();

        // TCP, three beats.
        out0 = n_out; meta0 = n_meta;
        send_pkt(mk_hdr(16'h0800, 8'd6, 32'h1122_3344), 3, 9'h1F0, 1'b1, 32'hC0DE_0001, tf, tl);
        wait_drain();
        check("tcp_meta", last_meta, 9'h1F1);
        check("tcp_beats", n_out - out0, 3);
        check("tcp_meta_strobes", n_meta - meta0, 1);

        // UDP with metadata_in_valid low: base is zero.
        send_pkt(mk_hdr(16'h0800, 8'd17, 32'h5566_7788), 2, 9'h1FF, 1'b0, 32'hC0DE_0002, tf, tl);
        wait_drain();
        check("udp_meta", last_meta, 9'h002);

        // IPv4 with another protocol, single beat.
        send_pkt(mk_hdr(16'h0800, 8'd1, 32'h99AA_BBCC), 1, 9'h000, 1'b1, 32'hC0DE_0003, tf, tl);
        wait_drain();
        check("other_meta", last_meta, 9'h003);

        // Backpressure: ready toggles every cycle over a 4-beat packet.
        out0 = n_out;
        bp_toggle = 1'b1;
        send_pkt(mk_hdr(16'h0800, 8'd6, 32'hDEAD_BEEF), 4, 9'h0AA, 1'b1, 32'hC0DE_0004, tf, tl);
        wait_drain();
        bp_toggle = 1'b0;
        @(negedge clk);
        check("bp_meta", last_meta, 9'h0A9);
        check("bp_beats", n_out - out0, 4);

        // Full throughput with ready held high.
        tready_level = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        send_pkt(mk_hdr(16'h0800, 8'd17, 32'h0BAD_F00D), 4, 9'h104, 1'b1, 32'hC0DE_0005, tf, tl);
        check("throughput_cycles", (tl - tf) / 10, 3);
        wait_drain();
        check("thru_meta", last_meta, 9'h106);

        // Reset in the middle of a 4-beat packet, after beat 2.
        drive_beat(mk_hdr(16'h0800, 8'd6, 32'h1357_9BDF), '1, 1'b0, 9'h0F0, 1'b1, tf);
        drive_beat({16{32'h2468_ACE0}}, '1, 1'b0, 9'h000, 1'b0, tf);
        s_axis_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        out0 = n_out;
        send_pkt(mk_hdr(16'h0800, 8'd17, 32'h0F0F_0F0F), 1, 9'h0F0, 1'b1, 32'hC0DE_0006, tf, tl);
        wait_drain();
        check("midrst_meta", last_meta, 9'h0F2);
        check("midrst_beats", n_out - out0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
